hub75_rx_monitor: RTL

- Panel-side receiver for the HUB75 output bus; the inverse of the timing generator and memory path.
- Oversamples led_clk, latch_enable, plane_oe, ABCDE and the r0..b1 lines, then reconstructs the shifted pixel stream.
- Emits a per-latch row summary: row, plane index, pixel count, checksum and OE on-time.
- Used for loopback diagnostics, or on a second FPGA to verify row length, BCM timing and frame cadence.

---
 rtl/hub75_rx_monitor_if.sv | 37 +++
 rtl/hub75_rx_monitor.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_rx_monitor_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface  : hub75_rx_monitor_if                                         |
// | Purpose    : HUB75 panel bus as seen by the receive monitor. The panel   |
// |              driver (or bench) drives it through the master modport; the |
// |              monitor samples it through the slave modport.               |
// | Signals    : hub_led_clk  shift clock                                    |
// |              hub_latch    latch_enable                                   |
// |              hub_oe       plane_oe                                       |
// |              hub_abcde    row address [4:0]                              |
// |              hub_rgb      {r0,g0,b0,r1,g1,b1}                            |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
interface hub75_rx_monitor_if;
    logic       hub_led_clk;
    logic       hub_latch;
    logic       hub_oe;
    logic [4:0] hub_abcde;
    logic [5:0] hub_rgb;

    modport master (
        output hub_led_clk,
        output hub_latch,
        output hub_oe,
        output hub_abcde,
        output hub_rgb
    );

    modport slave (
        input hub_led_clk,
        input hub_latch,
        input hub_oe,
        input hub_abcde,
        input hub_rgb
    );
endinterface
`default_nettype wire

// File: rtl/hub75_rx_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : hub75_rx_monitor                                            |
// | Purpose    : Panel-side HUB75 receiver. Oversamples the asynchronous     |
// |              HUB75 lines, rebuilds the shifted pixel stream and emits a  |
// |              per-latch row summary (row, plane, pixel count, checksum,   |
// |              OE on-time) plus frame cadence.                             |
// | Ports      : clk, reset (sync, active high), enable                      |
// |              pixels_per_row [9:0]   expected pixels per latch            |
// |              hub                    HUB75 bus (slave modport)            |
// |              pix_valid/pix_col/pix_rgb         captured pixel            |
// |              row_done/row_addr/row_plane/row_pix_count/row_checksum/     |
// |              oe_cycles                         row summary               |
// |              row_len_err (sticky), frame_sync, frame_count               |
// | Options    : HUB75_RX_GLITCH_FILTER_EN adds a 2-sample deglitch stage    |
// |              after the synchronizer (+1 clk latency).                    |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module hub75_rx_monitor #(
    parameter bit OE_ACTIVE_LOW = 1'b1,
    parameter int NUM_PLANES    = 6,
    parameter int SYNC_STAGES   = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          enable,
    input  wire logic [9:0]    pixels_per_row,
    hub75_rx_monitor_if.slave  hub,
    output logic               pix_valid,
    output logic [9:0]         pix_col,
    output logic [5:0]         pix_rgb,
    output logic               row_done,
    output logic [4:0]         row_addr,
    output logic [2:0]         row_plane,
    output logic [9:0]         row_pix_count,
    output logic [15:0]        row_checksum,
    output logic [15:0]        oe_cycles,
    output logic               row_len_err,
    output logic               frame_sync,
    output logic [15:0]        frame_count
);

    // Bundle layout: {led_clk, latch, oe, abcde[4:0], rgb[5:0]}
    localparam int         c_W          = 14;
    localparam logic [2:0] c_LAST_PLANE = 3'(NUM_PLANES - 1);
    localparam logic [0:0] c_ST_ALIGN   = 1'b0;
    localparam logic [0:0] c_ST_SHIFT   = 1'b1;

    logic [c_W-1:0] w_pins;
    logic [c_W-1:0] r_sync [SYNC_STAGES];
    logic [c_W-1:0] w_sync;
    logic [c_W-1:0] w_clean;

    assign w_pins = {hub.hub_led_clk, hub.hub_latch, hub.hub_oe, hub.hub_abcde, hub.hub_rgb};
    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= w_pins;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

`ifdef HUB75_RX_GLITCH_FILTER_EN
    // A bit follows the synchronizer only when the current sample matches the
    // previous one; otherwise the last accepted value is held.
    logic [c_W-1:0] r_glt_smp;
    logic [c_W-1:0] r_glt_hold;
    logic [c_W-1:0] w_glt_diff;

    assign w_glt_diff = w_sync ^ r_glt_smp;
    assign w_clean    = (w_sync & ~w_glt_diff) | (r_glt_hold & w_glt_diff);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_glt_smp  <= '0;
            r_glt_hold <= '0;
        end else begin
            r_glt_smp  <= w_sync;
            r_glt_hold <= w_clean;
        end
    end
`else
    assign w_clean = w_sync;
`endif

    // Edge detection
    logic       r_prev_led;
    logic       r_prev_latch;
    logic       w_led_rise;
    logic       w_latch_rise;
    logic       w_oe_act;
    logic [4:0] w_abcde;
    logic [5:0] w_rgb;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_led   <= 1'b0;
            r_prev_latch <= 1'b0;
        end else begin
            r_prev_led   <= w_clean[13];
            r_prev_latch <= w_clean[12];
        end
    end

    assign w_led_rise   = w_clean[13] & ~r_prev_led;
    assign w_latch_rise = w_clean[12] & ~r_prev_latch;
    assign w_oe_act     = OE_ACTIVE_LOW ? ~w_clean[11] : w_clean[11];
    assign w_abcde      = w_clean[10:6];
    assign w_rgb        = w_clean[5:0];

    // FSM: state register
    logic [0:0] r_state;
    logic [0:0] w_state_next;

    always_ff @(posedge clk) begin
        if (reset || !enable) r_state <= c_ST_ALIGN;
        else                  r_state <= w_state_next;
    end

    // FSM: next state. The first latch only establishes row alignment.
    always_comb begin
        w_state_next = r_state;
        if (r_state == c_ST_ALIGN && w_latch_rise) w_state_next = c_ST_SHIFT;
    end

    // FSM: decoded strobes
    logic w_do_pixel;
    logic w_do_latch;
    logic w_do_align;
    logic w_do_oe;

    always_comb begin
        w_do_pixel = 1'b0;
        w_do_latch = 1'b0;
        w_do_align = 1'b0;
        w_do_oe    = 1'b0;
        if (r_state == c_ST_SHIFT) begin
            w_do_pixel = w_led_rise;
            w_do_latch = w_latch_rise;
            w_do_oe    = w_oe_act;
        end else begin
            w_do_align = w_latch_rise;
        end
    end

    // Datapath
    logic [9:0]  r_col;
    logic [15:0] r_chk;
    logic [15:0] r_oe;
    logic [4:0]  r_prev_row;
    logic [2:0]  r_plane;
    logic [9:0]  w_col_next;
    logic [15:0] w_chk_next;
    logic [15:0] w_oe_next;
    logic [2:0]  w_plane_next;
    logic        w_frame_wrap;

    // The pixel of this cycle is folded in before a coincident latch reads it.
    assign w_col_next   = (w_do_pixel && r_col != 10'h3FF) ? r_col + 10'd1 : r_col;
    assign w_chk_next   = w_do_pixel ? ({r_chk[14:0], r_chk[15]} ^ {10'b0, w_rgb}) : r_chk;
    assign w_oe_next    = (w_do_oe && r_oe != 16'hFFFF) ? r_oe + 16'd1 : r_oe;
    assign w_plane_next = (w_abcde != r_prev_row)  ? 3'd0 :
                          (r_plane == c_LAST_PLANE) ? 3'd0 : r_plane + 3'd1;
    assign w_frame_wrap = (w_abcde == 5'd0) && (r_prev_row != 5'd0);

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            pix_valid     <= 1'b0;
            pix_col       <= '0;
            pix_rgb       <= '0;
            row_done      <= 1'b0;
            row_addr      <= '0;
            row_plane     <= '0;
            row_pix_count <= '0;
            row_checksum  <= '0;
            oe_cycles     <= '0;
            row_len_err   <= 1'b0;
            frame_sync    <= 1'b0;
            frame_count   <= '0;
            r_col         <= '0;
            r_chk         <= '0;
            r_oe          <= '0;
            r_prev_row    <= '0;
            r_plane       <= '0;
        end else begin
            pix_valid  <= w_do_pixel;
            row_done   <= w_do_latch;
            frame_sync <= w_do_latch && w_frame_wrap;
            if (w_do_pixel) begin
                pix_col <= r_col;
                pix_rgb <= w_rgb;
            end
            if (w_do_align) begin
                r_prev_row <= w_abcde;
                r_col      <= '0;
                r_chk      <= '0;
                r_oe       <= '0;
            end else if (w_do_latch) begin
                row_addr      <= w_abcde;
                row_plane     <= w_plane_next;
                row_pix_count <= w_col_next;
                row_checksum  <= w_chk_next;
                oe_cycles     <= r_oe;
                if (w_col_next != pixels_per_row) row_len_err <= 1'b1;
                if (w_frame_wrap) frame_count <= frame_count + 16'd1;
                r_plane    <= w_plane_next;
                r_prev_row <= w_abcde;
                r_col      <= '0;
                r_chk      <= '0;
                r_oe       <= '0;
            end else begin
                r_col <= w_col_next;
                r_chk <= w_chk_next;
                r_oe  <= w_oe_next;
            end
        end
    end

endmodule
`default_nettype wire
